idma_w_beat_sequencer: RTL

// - Sits directly downstream of the AXI R/W legalizer on the write side.
// - Consumes one legalized write-burst descriptor per handshake: offset, tailer, beat count, last flags.
// - Sequences data beats from the dataflow buffer onto the AXI W channel.
// - Per beat it generates the byte strobe and WLAST, and pulses completion at burst end.

---
 rtl/idma_w_seq_pkg.sv | 36 +++
 rtl/idma_strb_mask_gen.sv | 25 ++
 rtl/idma_w_beat_sequencer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/idma_w_seq_pkg.sv
// Shared types and strobe-mask helpers for the iDMA W-channel beat sequencer.
// Mask helpers work at a fixed maximum width; callers truncate to their strobe width.
package idma_w_seq_pkg;

    localparam int unsigned MaxStrbWidth   = 256;
    localparam int unsigned MaxOffsetWidth = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Legalized write-burst descriptor. super_last carries the midend "super" flag.
    typedef struct packed {
        logic [MaxOffsetWidth-1:0] offset;
        logic [MaxOffsetWidth-1:0] tailer;
        logic [7:0]                num_beats;
        logic                      last;
        logic                      super_last;
    } w_seq_desc_t;

    // Bytes at or above the start offset are valid in the first beat.
    function automatic logic [MaxStrbWidth-1:0] mask_head(input logic [MaxOffsetWidth-1:0] offset);
        for (int unsigned i = 0; i < MaxStrbWidth; i++) begin
            mask_head[i] = (i >= 32'(offset));
        end
    endfunction

    // Bytes below the tailer are valid in the last beat; tailer 0 means a full beat.
    function automatic logic [MaxStrbWidth-1:0] mask_tail(input logic [MaxOffsetWidth-1:0] tailer);
        for (int unsigned i = 0; i < MaxStrbWidth; i++) begin
            mask_tail[i] = (tailer == '0) || (i < 32'(tailer));
        end
    endfunction

endpackage

// File: rtl/idma_strb_mask_gen.sv
// Combinational W strobe generator: head mask on the first beat, tail mask on the last.
module idma_strb_mask_gen
    import idma_w_seq_pkg::*;
#(
    parameter int unsigned StrbWidth   = 4,
    parameter int unsigned OffsetWidth = 2
) (
    input  logic                   first_i,
    input  logic                   is_last_i,
    input  logic [OffsetWidth-1:0] offset_i,
    input  logic [OffsetWidth-1:0] tailer_i,
    output logic [StrbWidth-1:0]   strb_o
);

    logic [StrbWidth-1:0] head;
    logic [StrbWidth-1:0] tail;

    // A single-beat burst ANDs both masks.
    always_comb begin
        head   = first_i   ? StrbWidth'(mask_head(MaxOffsetWidth'(offset_i))) : '1;
        tail   = is_last_i ? StrbWidth'(mask_tail(MaxOffsetWidth'(tailer_i))) : '1;
        strb_o = head & tail;
    end

endmodule

// File: rtl/idma_w_beat_sequencer.sv
// iDMA write-side beat sequencer: takes legalized burst descriptors and drives AXI W beats.
// Optional build macro IDMA_W_BEAT_SEQ_PERF_EN adds beat and stall performance counters.
module idma_w_beat_sequencer
    import idma_w_seq_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [$clog2(DataWidth/8)-1:0]     req_offset_i,
    input  logic [$clog2(DataWidth/8)-1:0]     req_tailer_i,
    input  logic [7:0]                         req_num_beats_i,
    input  logic                               req_last_i,
    input  logic                               req_super_i,
    input  logic [DataWidth-1:0]               data_i,
    input  logic                               data_valid_i,
    output logic                               data_ready_o,
    output logic [DataWidth-1:0]               w_data_o,
    output logic [DataWidth/8-1:0]             w_strb_o,
    output logic                               w_last_o,
    output logic                               w_valid_o,
    input  logic                               w_ready_i,
    input  logic                               kill_i,
    output logic                               burst_done_o,
    output logic                               tf_done_o,
    output logic                               super_done_o,
`ifdef IDMA_W_BEAT_SEQ_PERF_EN
    output logic [31:0]                        perf_beats_o,
    output logic [31:0]                        perf_stall_o,
`endif
    output logic                               busy_o
);

    localparam int unsigned StrbWidth   = DataWidth / 8;
    localparam int unsigned OffsetWidth = $clog2(StrbWidth);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 first_q, first_d;
    w_seq_desc_t          desc_q, desc_d;
    logic                 fire, last_fire, accept;
    logic [StrbWidth-1:0] strb;

    // Next-state, handshake and descriptor-load logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        desc_d       = desc_q;
        req_ready_o  = 1'b0;
        w_valid_o    = 1'b0;
        data_ready_o = 1'b0;
        fire         = 1'b0;
        last_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = !kill_i;
            end
            BURST: begin
                w_valid_o    = data_valid_i & !kill_i;
                data_ready_o = w_ready_i & !kill_i;
                fire         = data_valid_i & w_ready_i & !kill_i;
                last_fire    = fire & (cnt_q == '0);
                req_ready_o  = last_fire;
                if (kill_i) begin
                    state_d = IDLE;
                end else if (fire) begin
                    first_d = 1'b0;
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q == '0) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_o = req_ready_o & !rst_i;
        accept      = req_valid_i & req_ready_o;
        // Accepting on the last fire overrides the exit to IDLE: no bubble between bursts.
        if (accept) begin
            state_d           = BURST;
            cnt_d             = req_num_beats_i;
            first_d           = 1'b1;
            desc_d.offset     = MaxOffsetWidth'(req_offset_i);
            desc_d.tailer     = MaxOffsetWidth'(req_tailer_i);
            desc_d.num_beats  = req_num_beats_i;
            desc_d.last       = req_last_i;
            desc_d.super_last = req_super_i;
        end
    end

    // State, beat counter and descriptor registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
            desc_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
            desc_q  <= desc_d;
        end
    end

    idma_strb_mask_gen #(
        .StrbWidth   (StrbWidth),
        .OffsetWidth (OffsetWidth)
    ) i_strb_mask_gen (
        .first_i   (first_q),
        .is_last_i (cnt_q == '0),
        .offset_i  (desc_q.offset[OffsetWidth-1:0]),
        .tailer_i  (desc_q.tailer[OffsetWidth-1:0]),
        .strb_o    (strb)
    );

    assign w_data_o     = data_i;
    assign w_strb_o     = (state_q == BURST) ? strb : '0;
    assign w_last_o     = (state_q == BURST) && (cnt_q == '0);
    assign busy_o       = (state_q == BURST);
    assign burst_done_o = last_fire;
    assign tf_done_o    = last_fire & desc_q.last;
    assign super_done_o = last_fire & desc_q.super_last;

`ifdef IDMA_W_BEAT_SEQ_PERF_EN
    logic [31:0] perf_beats_q, perf_beats_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Wrapping beat and back-pressure stall counters.
    always_comb begin
        perf_beats_d = perf_beats_q + (fire ? 32'd1 : 32'd0);
        perf_stall_d = perf_stall_q +
                       (((state_q == BURST) && data_valid_i && !w_ready_i) ? 32'd1 : 32'd0);
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_beats_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_beats_q <= perf_beats_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_beats_o = perf_beats_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule
